wb_pipe2classic: RTL and testbench

- Single-clock bridge between a pipelined Wishbone master (B4 pipelined: stall, no wait for ack per request) and a classic single-request slave port.
- Sits directly upstream of the clock-domain-crossing core, which only handles one classic cycle at a time.
- Buffers up to DEPTH requests, issues them strictly in order, one at a time, and returns acks and read data in order.

---
 rtl/wb_bridge_pkg.sv | 9 +
 rtl/wb_sync_fifo.sv | 50 +++++
 rtl/wb_pipe2classic.sv | 89 ++++++++
 tb/tb_wb_pipe2classic.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bridge_pkg.sv
// wb_bridge_pkg: shared widths, request-entry sizing and FSM encoding for the pipelined-to-classic Wishbone bridge
package wb_bridge_pkg;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;
  function automatic int req_w(input int aw);
    return aw + WB_DW + WB_SW + 1;
  endfunction
endpackage

// File: rtl/wb_sync_fifo.sv
// wb_sync_fifo: request FIFO exposing head and next entry, with a flush that can keep an in-flight head
module wb_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_keep_head_i,
  input  logic                   head_busy_i,
  input  logic [DW-1:0]          din_i,
  output logic [DW-1:0]          head_o,
  output logic [DW-1:0]          next_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_en, keep;
  // a flush keeps only the head that is still on the bus and not leaving this cycle
  always_comb begin
    keep  = head_busy_i & ~pop_i;
    wr_en = push_i & ~flush_keep_head_i;
    rd_d  = rd_q + PW'(pop_i);
    wr_d  = flush_keep_head_i ? rd_d + PW'(keep) : wr_q + PW'(wr_en);
    cnt_d = flush_keep_head_i ? CW'(keep) : cnt_q + CW'(wr_en) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (wr_en) mem_q[wr_q] <= din_i;
    end
  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_q + PW'(1)];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/wb_pipe2classic.sv
// wb_pipe2classic: buffers pipelined Wishbone requests and replays them one at a time as classic cycles
module wb_pipe2classic
  import wb_bridge_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [AW-1:0]    wbm_adr_i,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic [WB_SW-1:0] wbm_sel_i,
  input  logic             wbm_we_i,
  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  output logic             wbm_stall_o,
  output logic             wbm_ack_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [AW-1:0]    wbs_adr_o,
  output logic [WB_DW-1:0] wbs_dat_o,
  output logic [WB_SW-1:0] wbs_sel_o,
  output logic             wbs_we_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  input  logic [WB_DW-1:0] wbs_dat_i,
  input  logic             wbs_ack_i
);
  localparam int EW = req_w(AW);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [EW-1:0] head, nxt, ld_ent;
  logic [CW-1:0] count;
  logic full, empty, push, abort, ack_ok, ld, drop_q, drop_d;
  state_e state_q, state_d;
  assign abort       = ~wbm_cyc_i & ~empty;
  assign wbm_stall_o = full | (drop_q & ~empty);
  assign push        = wbm_cyc_i & wbm_stb_i & ~wbm_stall_o;
  assign ack_ok      = (state_q == ACTIVE) & wbs_ack_i;
  wb_sync_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i            (wb_clk),
    .rst_ni           (wb_rst_n),
    .push_i           (push),
    .pop_i            (ack_ok),
    .flush_keep_head_i(abort),
    .head_busy_i      (state_q == ACTIVE),
    .din_i            ({wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i}),
    .head_o           (head),
    .next_o           (nxt),
    .count_o          (count),
    .full_o           (full),
    .empty_o          (empty)
  );
  // back-to-back issue needs the entry behind the head, which must already be queued
  always_comb begin
    state_d = state_q;
    drop_d  = 1'b0;
    ld      = 1'b0;
    ld_ent  = head;
    if (state_q == IDLE) begin
      ld      = ~empty & ~abort;
      state_d = ld ? ACTIVE : IDLE;
    end else begin
      drop_d  = ~wbs_ack_i & (drop_q | abort);
      ld      = wbs_ack_i & (count > CW'(1)) & ~abort;
      ld_ent  = nxt;
      state_d = (wbs_ack_i & ~ld) ? IDLE : ACTIVE;
    end
  end
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      wbm_ack_o <= 1'b0;
      wbm_dat_o <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      wbs_cyc_o <= state_d == ACTIVE;
      wbs_stb_o <= state_d == ACTIVE;
      wbm_ack_o <= ack_ok & ~drop_q & ~abort;
      if (ack_ok) wbm_dat_o <= wbs_dat_i;
      if (ld) {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o} <= ld_ent;
    end
endmodule

// File: tb/tb_wb_pipe2classic.sv
// tb_wb_pipe2classic: directed self-checking bench for the pipelined-to-classic Wishbone bridge
module tb_wb_pipe2classic;
  logic        wb_clk, wb_rst_n;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbm_sel_i, wbs_sel_o;
  logic        wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_stall_o, wbm_ack_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i;
  int n_cmp, n_bad;
  wb_pipe2classic #(.AW(32), .DEPTH(4)) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .wbm_adr_i  (wbm_adr_i),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_sel_i  (wbm_sel_i),
    .wbm_we_i   (wbm_we_i),
    .wbm_cyc_i  (wbm_cyc_i),
    .wbm_stb_i  (wbm_stb_i),
    .wbm_stall_o(wbm_stall_o),
    .wbm_ack_o  (wbm_ack_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbs_adr_o  (wbs_adr_o),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_sel_o  (wbs_sel_o),
    .wbs_we_o   (wbs_we_o),
    .wbs_cyc_o  (wbs_cyc_o),
    .wbs_stb_o  (wbs_stb_o),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_i  (wbs_ack_i)
  );
  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rd_dat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic we);
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    wbm_adr_i = a;
    wbm_dat_i = d;
    wbm_sel_i = 4'hF;
    wbm_we_i  = we;
  endtask
  initial begin
    int issued, got, s, wcnt, lat;
    n_cmp = 0; n_bad = 0;
    wb_rst_n = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbs_dat_i = '0; wbs_ack_i = 1'b0;
    tick();
    tick();
    chk("rst_ack", 32'(wbm_ack_o), 32'd0);
    chk("rst_mdat", wbm_dat_o, 32'd0);
    chk("rst_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbs_stb_o), 32'd0);
    chk("rst_adr", wbs_adr_o, 32'd0);
    chk("rst_stall", 32'(wbm_stall_o), 32'd0);
    wb_rst_n = 1'b1;
    // single read
    req(32'h100, 32'h0, 1'b0);
    tick();
    wbm_stb_i = 1'b0;
    chk("rd_stb_early", 32'(wbs_stb_o), 32'd0);
    tick();
    chk("rd_stb", 32'(wbs_stb_o), 32'd1);
    chk("rd_adr", wbs_adr_o, 32'h100);
    chk("rd_we", 32'(wbs_we_o), 32'd0);
    tick();
    tick();
    chk("rd_hold", 32'(wbs_stb_o), 32'd1);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFEF00D;
    tick();
    wbs_ack_i = 1'b0;
    chk("rd_mack", 32'(wbm_ack_o), 32'd1);
    chk("rd_mdat", wbm_dat_o, 32'hCAFEF00D);
    chk("rd_cyc_drop", 32'(wbs_cyc_o), 32'd0);
    tick();
    chk("rd_mack_pulse", 32'(wbm_ack_o), 32'd0);
    wbm_cyc_i = 1'b0;
    // burst of four writes
    for (int i = 0; i < 4; i++) begin
      req(32'(4 * i), 32'h1000 + 32'(i), 1'b1);
      chk("wr_stall", 32'(wbm_stall_o), 32'd0);
      tick();
    end
    wbm_stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_stb", 32'(wbs_stb_o), 32'd1);
      chk("wr_adr", wbs_adr_o, 32'(4 * i));
      chk("wr_dat", wbs_dat_o, 32'h1000 + 32'(i));
      chk("wr_we", 32'(wbs_we_o), 32'd1);
      chk("wr_sel", 32'(wbs_sel_o), 32'hF);
      for (int w = 0; w < 4; w++) begin
        tick();
        if (w == 0) chk("wr_mack_idle", 32'(wbm_ack_o), 32'd0);
      end
      wbs_ack_i = 1'b1; wbs_dat_i = 32'h0;
      tick();
      wbs_ack_i = 1'b0;
      chk("wr_mack", 32'(wbm_ack_o), 32'd1);
      chk("wr_cyc", 32'(wbs_cyc_o), (i < 3) ? 32'd1 : 32'd0);
    end
    wbm_cyc_i = 1'b0;
    // fill to DEPTH with a stalled slave
    for (int i = 0; i < 5; i++) begin
      req(32'h200 + 32'(4 * i), 32'h0, 1'b0);
      chk("fill_stall", 32'(wbm_stall_o), (i < 4) ? 32'd0 : 32'd1);
      if (i < 4) tick();
    end
    tick();
    chk("fill_stall_hold", 32'(wbm_stall_o), 32'd1);
    chk("fill_adr0", wbs_adr_o, 32'h200);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hD0;
    tick();
    wbs_ack_i = 1'b0;
    chk("fill_unstall", 32'(wbm_stall_o), 32'd0);
    chk("fill_mack", 32'(wbm_ack_o), 32'd1);
    chk("fill_adr1", wbs_adr_o, 32'h204);
    tick();
    wbm_stb_i = 1'b0;
    for (int j = 1; j < 5; j++) begin
      chk("fill_drain_adr", wbs_adr_o, 32'h200 + 32'(4 * j));
      wbs_ack_i = 1'b1; wbs_dat_i = 32'hD0 + 32'(j);
      tick();
      wbs_ack_i = 1'b0;
      chk("fill_drain_mack", 32'(wbm_ack_o), 32'd1);
      chk("fill_drain_mdat", wbm_dat_o, 32'hD0 + 32'(j));
    end
    chk("fill_idle", 32'(wbs_cyc_o), 32'd0);
    wbm_cyc_i = 1'b0;
    // master abort with one request in flight
    for (int i = 0; i < 3; i++) begin
      req(32'h300 + 32'(4 * i), 32'h0, 1'b0);
      tick();
    end
    wbm_stb_i = 1'b0; wbm_cyc_i = 1'b0;
    tick();
    chk("abt_cyc", 32'(wbs_cyc_o), 32'd1);
    chk("abt_adr", wbs_adr_o, 32'h300);
    chk("abt_stall", 32'(wbm_stall_o), 32'd1);
    tick();
    chk("abt_cyc_hold", 32'(wbs_cyc_o), 32'd1);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hBAD;
    tick();
    wbs_ack_i = 1'b0;
    chk("abt_no_mack", 32'(wbm_ack_o), 32'd0);
    chk("abt_cyc_drop", 32'(wbs_cyc_o), 32'd0);
    chk("abt_unstall", 32'(wbm_stall_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abt_no_issue", 32'(wbs_stb_o), 32'd0);
      chk("abt_no_mack2", 32'(wbm_ack_o), 32'd0);
    end
    // asynchronous reset during a back-to-back transfer
    req(32'h400, 32'h0, 1'b0);
    tick();
    wbm_adr_i = 32'h404;
    tick();
    wbm_stb_i = 1'b0;
    chk("rst_pre_adr", wbs_adr_o, 32'h400);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h44;
    tick();
    wbs_ack_i = 1'b0;
    chk("rst_pre_mack", 32'(wbm_ack_o), 32'd1);
    chk("rst_pre_cyc", 32'(wbs_cyc_o), 32'd1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("arst_stb", 32'(wbs_stb_o), 32'd0);
    chk("arst_mack", 32'(wbm_ack_o), 32'd0);
    chk("arst_mdat", wbm_dat_o, 32'd0);
    chk("arst_adr", wbs_adr_o, 32'd0);
    tick();
    wb_rst_n = 1'b1;
    req(32'h500, 32'h0, 1'b0);
    tick();
    wbm_stb_i = 1'b0;
    tick();
    chk("post_rst_stb", 32'(wbs_stb_o), 32'd1);
    chk("post_rst_adr", wbs_adr_o, 32'h500);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h55AA;
    tick();
    wbs_ack_i = 1'b0;
    chk("post_rst_mack", 32'(wbm_ack_o), 32'd1);
    chk("post_rst_mdat", wbm_dat_o, 32'h55AA);
    chk("post_rst_idle", 32'(wbs_cyc_o), 32'd0);
    wbm_cyc_i = 1'b0;
    tick();
    // ten reads through wrapping pointers with random slave latency
    issued = 0; got = 0; s = 0; wcnt = 0; lat = int'($urandom_range(0, 4));
    wbm_cyc_i = 1'b1;
    for (int c = 0; c < 300 && got < 10; c++) begin
      if (issued < 10) begin
        req(32'h600 + 32'(4 * issued), 32'h0, 1'b0);
        if (!wbm_stall_o) issued++;
      end else wbm_stb_i = 1'b0;
      wbs_ack_i = 1'b0;
      if (wbs_stb_o) begin
        if (wcnt == lat) begin
          chk("wrap_sadr", wbs_adr_o, 32'h600 + 32'(4 * s));
          s++;
          wbs_ack_i = 1'b1;
          wbs_dat_i = rd_dat(wbs_adr_o);
          wcnt = 0;
          lat = int'($urandom_range(0, 4));
        end else wcnt++;
      end
      tick();
      if (wbm_ack_o) begin
        chk("wrap_mdat", wbm_dat_o, rd_dat(32'h600 + 32'(4 * got)));
        got++;
      end
    end
    wbs_ack_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_cyc_i = 1'b0;
    chk("wrap_count", 32'(got), 32'd10);
    tick();
    chk("wrap_idle", 32'(wbs_cyc_o), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
